alu_s_axi_slave: RTL and testbench

AXI4-Lite slave (responder) for the ALU peripheral. It terminates the S00_AXI port that the AXI4-Lite master issues single-beat register writes and reads to. It holds two operand registers, a control register and a scratch register. It also exposes a registered, read-only ALU result. All responses are OKAY.

---
 rtl/alu_s_axi_slave.sv | 216 +++++++++++++++++++++
 tb/tb_alu_s_axi_slave.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_s_axi_slave.sv
// AXI4-Lite register slave for the ALU peripheral: OPA, OPB, CTRL,
// SCRATCH (RW) and a registered, read-only RESULT.
//
// Ports
//   S_AXI_ACLK, S_AXI_ARESETN : clock, async active-low reset
//   S_AXI_AW* / S_AXI_W*      : write address / data (single beat)
//   S_AXI_B*                  : write response (always OKAY)
//   S_AXI_AR* / S_AXI_R*      : read address / data (always OKAY)
module alu_s_axi_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  typedef logic [DW-1:0] word_t;

  logic [0:0] w_state;
  logic [0:0] r_state;
  logic       aw_rdy_q;
  logic       ar_rdy_q;
  word_t      rdata_q;

  word_t      opa_q;
  word_t      opb_q;
  word_t      ctrl_q;
  word_t      scratch_q;
  word_t      result_q;
  word_t      alu_next;
  word_t      rd_mux;

  logic [2:0] aw_idx;
  logic [2:0] ar_idx;
  logic [7:0] aw_sel;
  logic [7:0] ar_sel;
  logic       wr_fire;
  logic       rd_fire;
  logic [4:0] shamt;
  logic [2:0] op;

  logic       unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[1:0],
                       S_AXI_ARADDR[1:0]};

  assign aw_idx = S_AXI_AWADDR[4:2];
  assign ar_idx = S_AXI_ARADDR[4:2];
  assign aw_sel = 8'b1 << aw_idx;
  assign ar_sel = 8'b1 << ar_idx;

  // Ready is a registered pulse; the transfer happens on the
  // edge where ready and the valids are seen together.
  assign wr_fire = aw_rdy_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_fire = ar_rdy_q & S_AXI_ARVALID;

  assign S_AXI_AWREADY = aw_rdy_q;
  assign S_AXI_WREADY  = aw_rdy_q;
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = ar_rdy_q;
  assign S_AXI_RVALID  = (r_state == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;

  function automatic word_t merge(
    input word_t           old,
    input word_t           d,
    input logic [SW-1:0]   s
  );
    word_t r;
    r = old;
    for (int i = 0; i < SW; i++) begin
      if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    end
    return r;
  endfunction

  // Write channel
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state  <= W_IDLE;
      aw_rdy_q <= 1'b0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (wr_fire) begin
            aw_rdy_q <= 1'b0;
            w_state  <= W_RESP;
          end else if (!aw_rdy_q &&
                       S_AXI_AWVALID &&
                       S_AXI_WVALID) begin
            aw_rdy_q <= 1'b1;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Register file; RESULT and reserved slots drop writes
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      opa_q     <= '0;
      opb_q     <= '0;
      ctrl_q    <= '0;
      scratch_q <= '0;
    end else if (wr_fire) begin
      unique case (1'b1)
        aw_sel[0]: opa_q <= merge(opa_q, S_AXI_WDATA, S_AXI_WSTRB);
        aw_sel[1]: opb_q <= merge(opb_q, S_AXI_WDATA, S_AXI_WSTRB);
        aw_sel[2]: ctrl_q <= merge(ctrl_q, S_AXI_WDATA, S_AXI_WSTRB);
        aw_sel[3]: scratch_q <= merge(scratch_q, S_AXI_WDATA,
                                      S_AXI_WSTRB);
        default: ;
      endcase
    end
  end

  // Read mux
  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      ar_sel[0]: rd_mux = opa_q;
      ar_sel[1]: rd_mux = opb_q;
      ar_sel[2]: rd_mux = ctrl_q;
      ar_sel[3]: rd_mux = scratch_q;
      ar_sel[4]: rd_mux = result_q;
      default:   rd_mux = '0;
    endcase
  end

  // Read channel
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state  <= R_IDLE;
      ar_rdy_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (rd_fire) begin
            ar_rdy_q <= 1'b0;
            rdata_q  <= rd_mux;
            r_state  <= R_DATA;
          end else if (!ar_rdy_q && S_AXI_ARVALID) begin
            ar_rdy_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ALU
  assign op    = ctrl_q[2:0];
  assign shamt = opb_q[4:0];

  always_comb begin
    alu_next = opa_q;
    unique case (op)
      3'd0: alu_next = opa_q + opb_q;
      3'd1: alu_next = opa_q - opb_q;
      3'd2: alu_next = opa_q & opb_q;
      3'd3: alu_next = opa_q | opb_q;
      3'd4: alu_next = opa_q ^ opb_q;
      3'd5: alu_next = opa_q << shamt;
      3'd6: alu_next = opa_q >> shamt;
      3'd7: alu_next = opa_q;
      default: alu_next = opa_q;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      result_q <= '0;
    end else begin
      result_q <= alu_next;
    end
  end

endmodule

// File: tb/tb_alu_s_axi_slave.sv
// Bench for alu_s_axi_slave: directed plus random AXI-Lite traffic,
// checked against a register-array model of the peripheral.
module tb_alu_s_axi_slave;

  logic        tb_ACLK;
  logic        aresetn;
  logic [4:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [4:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int checks = 0;
  int errors = 0;

  alu_s_axi_slave dut (
    .S_AXI_ACLK    (tb_ACLK),
    .S_AXI_ARESETN (aresetn),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready)
  );

  initial tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timed out t=%0t", nm, $time);
  endtask

  // Reference model: architectural registers, the RESULT register
  // as the bus sees it, and expected read data in flight.
  logic [31:0] m_reg [0:3];
  logic [31:0] m_res;
  logic [31:0] m_nres;
  logic [31:0] rq [$];
  logic        prev_rv;
  logic [31:0] prev_rd;
  logic [2:0]  mi;

  function automatic logic [31:0] alu_ref(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [2:0]  o);
    case (o)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b[4:0];
      3'd6: return a >> b[4:0];
      default: return a;
    endcase
  endfunction

  // Compare process: checks what is visible now, then predicts the
  // effect of the coming rising edge.
  always @(negedge tb_ACLK) begin
    if (!aresetn) begin
      for (int i = 0; i < 4; i++) m_reg[i] = '0;
      m_res   = '0;
      prev_rv = 1'b0;
      prev_rd = '0;
      rq.delete();
    end else begin
      chk("aw_eq_w", {31'b0, awready}, {31'b0, wready});
      if (bvalid) begin
        chk("bresp", {30'b0, bresp}, 32'd0);
        chk("aw_during_b", {31'b0, awready}, 32'd0);
      end
      if (rvalid) begin
        chk("rresp", {30'b0, rresp}, 32'd0);
        chk("ar_during_r", {31'b0, arready}, 32'd0);
      end
      if (prev_rv) begin
        chk("rvalid_hold", {31'b0, rvalid}, 32'd1);
        chk("rdata_stable", rdata, prev_rd);
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) tmo("rdata_unexpected");
        else chk("rdata", rdata, rq.pop_front());
      end
      prev_rv = rvalid && !rready;
      prev_rd = rdata;
      if (arready && arvalid) begin
        mi = araddr[4:2];
        if (mi < 3'd4) rq.push_back(m_reg[mi[1:0]]);
        else if (mi == 3'd4) rq.push_back(m_res);
        else rq.push_back(32'd0);
      end
      m_nres = alu_ref(m_reg[0], m_reg[1], m_reg[2][2:0]);
      if (awready && awvalid && wvalid) begin
        mi = awaddr[4:2];
        if (mi < 3'd4) begin
          for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) m_reg[mi[1:0]][8*i +: 8] = wdata[8*i +: 8];
          end
        end
      end
      m_res = m_nres;
    end
  end

  task automatic axi_write(input logic [4:0]  a,
                           input logic [31:0] d,
                           input logic [3:0]  s,
                           input int          lag,
                           input int          bdly);
    int n;
    awaddr  = a;
    wdata   = d;
    wstrb   = s;
    awvalid = 1'b1;
    for (int i = 0; i < lag; i++) begin
      @(negedge tb_ACLK);
      chk("aw_alone", {30'b0, awready, wready}, 32'd0);
      @(posedge tb_ACLK);
      #1;
    end
    wvalid = 1'b1;
    n = 0;
    @(negedge tb_ACLK);
    while (!(awready && wready)) begin
      n++;
      if (n > 100) begin
        tmo("aw_handshake");
        break;
      end
      @(negedge tb_ACLK);
    end
    @(posedge tb_ACLK);
    #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    // Offer a second write while the response is held back.
    for (int i = 0; i < bdly; i++) begin
      awaddr  = 5'h1c;
      awvalid = 1'b1;
      wvalid  = 1'b1;
      @(negedge tb_ACLK);
      chk("bvalid_hold", {31'b0, bvalid}, 32'd1);
      chk("aw_blocked", {31'b0, awready}, 32'd0);
      @(posedge tb_ACLK);
      #1;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b1;
    n = 0;
    @(negedge tb_ACLK);
    while (!bvalid) begin
      n++;
      if (n > 100) begin
        tmo("bvalid");
        break;
      end
      @(negedge tb_ACLK);
    end
    @(posedge tb_ACLK);
    #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input  logic [4:0]  a,
                          input  int          rdly,
                          output logic [31:0] d);
    int n;
    araddr  = a;
    arvalid = 1'b1;
    n = 0;
    @(negedge tb_ACLK);
    while (!arready) begin
      n++;
      if (n > 100) begin
        tmo("ar_handshake");
        break;
      end
      @(negedge tb_ACLK);
    end
    @(posedge tb_ACLK);
    #1;
    arvalid = 1'b0;
    for (int i = 0; i < rdly; i++) begin
      @(posedge tb_ACLK);
      #1;
    end
    rready = 1'b1;
    n = 0;
    d = '0;
    @(negedge tb_ACLK);
    while (!rvalid) begin
      n++;
      if (n > 100) begin
        tmo("rvalid");
        break;
      end
      @(negedge tb_ACLK);
    end
    d = rdata;
    @(posedge tb_ACLK);
    #1;
    rready = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  logic [31:0] rd;
  logic [31:0] rd2;
  logic [31:0] wv [0:3];
  logic [4:0]  ra;
  logic [4:0]  rb;
  int          n;

  initial begin
    aresetn = 1'b0;
    awaddr  = '0;
    awprot  = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    araddr  = '0;
    arprot  = '0;
    arvalid = 1'b0;
    rready  = 1'b0;
    repeat (3) @(posedge tb_ACLK);
    #1;
    chk("rst_ready", {29'b0, awready, wready, arready}, 32'd0);
    chk("rst_valid", {30'b0, bvalid, rvalid}, 32'd0);
    chk("rst_resp", {28'b0, bresp, rresp}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    aresetn = 1'b1;
    @(posedge tb_ACLK);
    #1;

    // Scratch readback at the four RW offsets
    wv[0] = 32'h0101FFFF;
    wv[1] = 32'hABCD0001;
    wv[2] = 32'hDEAD0011;
    wv[3] = 32'hBEEF0011;
    for (int i = 0; i < 4; i++) begin
      axi_write(5'(i * 4), wv[i], 4'hF, 0, 0);
      axi_read(5'(i * 4), 0, rd);
      chk("readback", rd, wv[i]);
    end

    // ALU operations
    axi_write(5'h00, 32'hFFFFFFFF, 4'hF, 0, 0);
    axi_write(5'h04, 32'h00000002, 4'hF, 0, 0);
    axi_write(5'h08, 32'd0, 4'hF, 0, 0);
    axi_read(5'h10, 0, rd);
    chk("alu_add", rd, 32'h00000001);
    axi_write(5'h08, 32'd1, 4'hF, 0, 0);
    axi_read(5'h10, 0, rd);
    chk("alu_sub", rd, 32'hFFFFFFFD);
    axi_write(5'h08, 32'd5, 4'hF, 0, 0);
    axi_read(5'h10, 0, rd);
    chk("alu_shl", rd, 32'hFFFFFFFC);
    axi_write(5'h08, 32'd6, 4'hF, 0, 0);
    axi_read(5'h10, 0, rd);
    chk("alu_shr", rd, 32'h3FFFFFFF);
    axi_write(5'h10, 32'h12345678, 4'hF, 0, 0);
    axi_read(5'h10, 0, rd);
    chk("result_ro", rd, 32'h3FFFFFFF);

    // Byte strobes, including a no-op strobe
    axi_write(5'h0C, 32'h11223344, 4'hF, 0, 0);
    axi_write(5'h0C, 32'hAABBCCDD, 4'b0101, 0, 0);
    axi_read(5'h0C, 0, rd);
    chk("strobe", rd, 32'h11BB33DD);
    axi_write(5'h0F, 32'h99999999, 4'b0000, 0, 0);
    axi_read(5'h0D, 0, rd);
    chk("strobe_none", rd, 32'h11BB33DD);
    axi_read(5'h18, 0, rd);
    chk("reserved", rd, 32'd0);

    // AW ahead of W, BREADY and RREADY backpressure
    axi_write(5'h0C, 32'h600DCAFE, 4'hF, 3, 5);
    axi_read(5'h0C, 4, rd);
    chk("rd_backpressure", rd, 32'h600DCAFE);

    // Same-edge read and write of OPA
    axi_write(5'h00, 32'h9, 4'hF, 0, 0);
    fork
      axi_write(5'h00, 32'h5, 4'hF, 0, 0);
      axi_read(5'h00, 0, rd);
    join
    chk("same_edge_old", rd, 32'h9);
    axi_read(5'h00, 0, rd);
    chk("same_edge_new", rd, 32'h5);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      ra = 5'($urandom);
      rb = 5'($urandom);
      case ($urandom_range(0, 2))
        0: axi_write(ra, $urandom, 4'($urandom),
                     $urandom_range(0, 2), $urandom_range(0, 3));
        1: axi_read(ra, $urandom_range(0, 3), rd);
        default: begin
          fork
            axi_write(ra, $urandom, 4'($urandom), 0,
                      $urandom_range(0, 2));
            axi_read(rb, $urandom_range(0, 2), rd2);
          join
        end
      endcase
    end

    // Reset while a write response is pending
    awaddr  = 5'h0C;
    wdata   = 32'h77777777;
    wstrb   = 4'hF;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    n = 0;
    @(negedge tb_ACLK);
    while (!awready) begin
      n++;
      if (n > 100) begin
        tmo("rst_aw");
        break;
      end
      @(negedge tb_ACLK);
    end
    @(posedge tb_ACLK);
    #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    @(negedge tb_ACLK);
    chk("pre_rst_bvalid", {31'b0, bvalid}, 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("rst_bvalid", {31'b0, bvalid}, 32'd0);
    chk("rst_hs", {28'b0, awready, wready, arready, rvalid},
        32'd0);
    repeat (2) @(negedge tb_ACLK);
    @(posedge tb_ACLK);
    #1;
    aresetn = 1'b1;
    @(posedge tb_ACLK);
    #1;
    for (int i = 0; i < 8; i++) begin
      axi_read(5'(i * 4), 0, rd);
      chk("post_rst_zero", rd, 32'd0);
    end
    axi_write(5'h0C, 32'hCAFEF00D, 4'hF, 0, 1);
    axi_read(5'h0C, 0, rd);
    chk("post_rst_rw", rd, 32'hCAFEF00D);

    repeat (3) @(posedge tb_ACLK);
    if (rq.size() != 0) tmo("rq_drain");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
